// File: rtl/rms_bcd_conv.sv
// ---------------------------------------------------------------------------
// rms_bcd_conv
// Downstream stage of the RMS block. Captures the binary RMS value on its
// update strobe, optionally scales it to display units (multiply then right
// shift) and converts it to packed BCD with an iterative double-dabble
// sequencer. The result saturates to all nines when it does not fit in
// DIGITS decimal digits, and the overflow flag is raised.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   din_i          binary RMS value (DATA_W bits)
//   din_update_i   one-cycle strobe, din_i valid
//   clr_i          synchronous clear, same effect as reset
//   bcd_o          packed BCD, digit 0 (units) in bits [3:0]
//   ovf_o          value exceeded 10^DIGITS-1, bcd_o saturated
//   dout_update_o  one-cycle strobe, bcd_o/ovf_o updated
//   busy_o         conversion in progress
// ---------------------------------------------------------------------------
module rms_bcd_conv #(
  parameter int DATA_W      = 16,
  parameter int MUL_W       = 8,
  parameter int SCALE_MUL   = 1,
  parameter int SCALE_SHIFT = 0,
  parameter int DIGITS      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     din_i,
  input  logic                  din_update_i,
  input  logic                  clr_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o,
  output logic                  dout_update_o,
  output logic                  busy_o
);

  localparam int VW    = DATA_W + MUL_W;
  localparam int BW    = 4 * DIGITS;
  localparam int SW    = BW + VW;
  localparam int CNT_W = 5;

  localparam logic [MUL_W-1:0] MUL_C    = MUL_W'(SCALE_MUL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VW - 1);
  localparam logic [BW-1:0]    BCD_SAT  = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCALE = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Largest value representable in n decimal digits (10^n - 1).
  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10_m1(DIGITS);

  // One double-dabble iteration: bias every BCD digit >= 5 by 3, then shift
  // the whole register left so the next binary bit enters the units digit.
  function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int d = 0; d < DIGITS; d++) begin
      if (t[VW+4*d +: 4] >= 4'd5) begin
        t[VW+4*d +: 4] = t[VW+4*d +: 4] + 4'd3;
      end else begin
        t[VW+4*d +: 4] = t[VW+4*d +: 4];
      end
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   din_cap_q, din_cap_d;
  logic [DATA_W-1:0]   pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [SW-1:0]       sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                upd_q, upd_d;
  logic                busy_q, busy_d;

  logic [VW-1:0]       p_s;
  logic [VW-1:0]       v_s;
  logic                ovf_s;

  // Scaled value: full-width product, right shift, range check.
  always_comb begin
    p_s   = VW'(din_cap_q) * VW'(MUL_C);
    v_s   = p_s >> SCALE_SHIFT;
    ovf_s = (64'(v_s) > MAX_VAL);
  end

  // Next-state and datapath update for the conversion sequencer.
  always_comb begin
    state_d    = state_q;
    din_cap_d  = din_cap_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    upd_d      = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        if (din_update_i) begin
          din_cap_d = din_i;
          state_d   = S_SCALE;
          busy_d    = 1'b1;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_SCALE: begin
        sr_d       = {{BW{1'b0}}, v_s};
        ovf_flag_d = ovf_s;
        cnt_d      = {CNT_W{1'b0}};
        state_d    = S_SHIFT;
        if (din_update_i) begin
          pend_d     = din_i;
          pend_vld_d = 1'b1;
        end else begin
          pend_vld_d = pend_vld_q;
        end
      end

      S_SHIFT: begin
        sr_d  = dabble_step(sr_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
        if (din_update_i) begin
          pend_d     = din_i;
          pend_vld_d = 1'b1;
        end else begin
          pend_vld_d = pend_vld_q;
        end
      end

      S_DONE: begin
        bcd_d = ovf_flag_q ? BCD_SAT : sr_q[SW-1:VW];
        ovf_d = ovf_flag_q;
        upd_d = 1'b1;
        // A strobe arriving now is newer than anything in the slot.
        if (din_update_i) begin
          din_cap_d  = din_i;
          pend_vld_d = 1'b0;
          state_d    = S_SCALE;
          busy_d     = 1'b1;
        end else if (pend_vld_q) begin
          din_cap_d  = pend_q;
          pend_vld_d = 1'b0;
          state_d    = S_SCALE;
          busy_d     = 1'b1;
        end else begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Clear wins over everything, dropping any in-flight or pending sample.
    if (clr_i) begin
      state_d    = S_IDLE;
      din_cap_d  = {DATA_W{1'b0}};
      pend_d     = {DATA_W{1'b0}};
      pend_vld_d = 1'b0;
      sr_d       = {SW{1'b0}};
      cnt_d      = {CNT_W{1'b0}};
      ovf_flag_d = 1'b0;
      bcd_d      = {BW{1'b0}};
      ovf_d      = 1'b0;
      upd_d      = 1'b0;
      busy_d     = 1'b0;
    end else begin
      upd_d      = upd_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      din_cap_q  <= {DATA_W{1'b0}};
      pend_q     <= {DATA_W{1'b0}};
      pend_vld_q <= 1'b0;
      sr_q       <= {SW{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      ovf_flag_q <= 1'b0;
      bcd_q      <= {BW{1'b0}};
      ovf_q      <= 1'b0;
      upd_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_cap_q  <= din_cap_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      upd_q      <= upd_d;
      busy_q     <= busy_d;
    end
  end

  assign bcd_o         = bcd_q;
  assign ovf_o         = ovf_q;
  assign dout_update_o = upd_q;
  assign busy_o        = busy_q;

endmodule

// File: doc/rms_bcd_conv.md
Name: rms_bcd_conv

Overview:
- Downstream stage of the RMS block: consumes the RMS result and its update strobe.
- Optionally scales the binary RMS value to display units (multiply, then right shift).
- Converts the scaled value to packed BCD with an iterative double-dabble sequencer.
- Output feeds the seven-segment display driver, saturates at the display range, and flags overflow.

Parameters:
- DATA_W, 16: width of the binary input (matches the RMS output).
- MUL_W, 8: width of the scale multiplier.
- SCALE_MUL, 1: unsigned scale factor, must be < 2^MUL_W.
- SCALE_SHIFT, 0: right shift applied after the multiply.
- DIGITS, 5: number of BCD digits produced.

Ports:
- clk  in  1: system clock.
- rst  in  1: reset, asynchronous, active-high.
- din_i  in  DATA_W: binary RMS value.
- din_update_i  in  1: one-cycle strobe, din_i valid.
- clr_i  in  1: synchronous clear.
- bcd_o  out  4*DIGITS: packed BCD, digit 0 (units) in bits [3:0].
- ovf_o  out  1: value exceeded 10^DIGITS-1, so bcd_o is saturated.
- dout_update_o  out  1: one-cycle strobe, bcd_o/ovf_o updated.
- busy_o  out  1: conversion in progress.

Behaviour:
- Reset (rst high, async): state IDLE; bcd_o=0, ovf_o=0, dout_update_o=0, busy_o=0; pending slot empty.
- clr_i (sync): same effect as reset on the next edge. It has priority over din_update_i in the same cycle, and any in-flight conversion or pending sample is dropped.
- Widths:
  - VW = DATA_W+MUL_W.
  - P = din*SCALE_MUL, computed at full VW width with no truncation.
  - V = P >> SCALE_SHIFT.
  - Shift register holds 4*DIGITS BCD bits plus VW binary bits.
- State machine IDLE -> SCALE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - din_update_i=1 at edge 0 captures din_i and moves to SCALE.
  - busy_o is 1 from that edge on.
- SCALE:
  - Edge 1 computes V and loads the binary part of the shift register; the BCD part is cleared.
  - Overflow flag = (V > 10^DIGITS-1), latched internally.
- SHIFT:
  - VW iterations on edges 2..VW+1.
  - Each iteration adds 3 to every BCD digit >= 5, then shifts left 1.
  - A 5-bit iteration counter (sized for VW) terminates the loop.
- DONE (edge VW+2):
  - bcd_o is set to the converted BCD, or all digits 4'h9 if overflow.
  - ovf_o is set to the flag.
  - dout_update_o=1 for exactly one cycle.
  - busy_o is deasserted unless a pending sample exists.
- Latency is fixed and independent of overflow: dout_update_o is high in the cycle after edge VW+2. With defaults (VW=24) that is 26 clocks after the capturing edge.
- Overflow does not shorten the sequence.
- bcd_o and ovf_o hold their values between updates; they change only in DONE, reset or clr.
- din_update_i while busy (SCALE/SHIFT/DONE):
  - The sample is stored in a one-deep pending slot; newer samples overwrite older ones, so the latest value wins.
  - At DONE with the slot full, the FSM goes directly to SCALE with the pending value, clears the slot, and keeps busy_o high.
  - din_update_i in the same cycle as DONE also goes to the pending slot and is processed next.
- din_i is sampled only on the strobe; later changes to din_i do not affect a running conversion.

Test Plan:
- Reset with defaults, then din_i=12345 with a 1-cycle strobe -> after 26 clocks bcd_o=20'h12345, ovf_o=0, dout_update_o high exactly 1 cycle, busy_o high for the 26 cycles.
- Boundary values: din_i=0 -> bcd_o=20'h00000; din_i=65535 -> 20'h65535, ovf_o=0.
- DIGITS=4, din_i=9999 -> bcd_o=16'h9999, ovf_o=0. Then din_i=10000 -> bcd_o=16'h9999, ovf_o=1, same 26-cycle latency.
- Scaling: SCALE_MUL=200, SCALE_SHIFT=8, din_i=1000 -> V=781, bcd_o=20'h00781.
- Back-to-back: strobe 100, then 200 at +3 clocks and 300 at +10 clocks -> outputs 00100 at +26, then 00300 with no idle gap. 200 is never output; exactly 2 dout_update_o pulses.
- Interrupts:
  - Strobe 4321, clr_i at +10 -> next edge bcd_o=0, busy_o=0, no dout_update_o.
  - Repeat, asserting rst asynchronously mid-SHIFT -> outputs 0 immediately; the next strobe converts normally.
